// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch unit feeding the single-cycle RV64 core.
//
// Issues sequential word fetches to instruction memory over a valid/ready
// request channel, accepts in-order responses, and buffers {pc, inst} pairs
// in a DEPTH-entry FIFO for the core. A redirect flushes the FIFO, restarts
// fetch at the new PC and discards responses still in flight.
//
// Ports:
//   clk, rst                 clock; asynchronous active-high reset
//   redirect_valid/_pc       core restart request (pc bits [1:0] ignored)
//   req_valid/ready/addr     fetch request channel to instruction memory
//   resp_valid/data          in-order response channel from memory
//   out_valid/ready/pc/inst  instruction handed to the core
//   stall_cnt                fetch-starved cycle counter
//
// Build option: define IFU_STALL_CNT_EN to generate the saturating
// stall_cnt counter; otherwise stall_cnt is tied to zero.

module ifu_fetch #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned CNT_W    = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        req_valid,
    input  logic        req_ready,
    output logic [63:0] req_addr,
    input  logic        resp_valid,
    input  logic [31:0] resp_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_pc,
    output logic [31:0] out_inst,
    output logic [31:0] stall_cnt
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [63:0]      fpc;
    logic [63:0]      rpc;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] drop_cnt;
    logic [CNT_W-1:0] live;
    logic [CNT_W-1:0] used;

    logic [63:0]      pc_mem   [DEPTH];
    logic [31:0]      inst_mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;

    logic             req_fire;
    logic             resp_ok;
    logic             push;
    logic             pop;
    logic [63:0]      redirect_aligned;
    logic             unused_pc_lsbs;

    assign redirect_aligned = {redirect_pc[63:2], 2'b00};
    assign unused_pc_lsbs   = ^redirect_pc[1:0];

    // Live requests will land in the FIFO; stale ones (drop_cnt) will not.
    // Live + buffered never exceeds DEPTH, so a push always has room.
    assign live      = outstanding - drop_cnt;
    assign used      = live + CNT_W'(count);
    assign req_valid = !rst && !redirect_valid && (used < CNT_W'(DEPTH));
    assign req_addr  = fpc;

    assign req_fire  = req_valid && req_ready;
    // A response with nothing outstanding is a protocol error and ignored.
    assign resp_ok   = resp_valid && (outstanding != '0);
    // Responses in a redirect cycle are stale by definition.
    assign push      = resp_ok && !redirect_valid && (drop_cnt == '0);
    assign pop       = out_valid && out_ready && !redirect_valid;

    assign out_valid = (count != '0);
    assign out_pc    = pc_mem[rd_ptr];
    assign out_inst  = inst_mem[rd_ptr];

    // Fetch/response address tracking and in-flight bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fpc         <= RESET_PC;
            rpc         <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding + CNT_W'(req_fire) - CNT_W'(resp_ok);
            if (redirect_valid) begin
                fpc      <= redirect_aligned;
                rpc      <= redirect_aligned;
                // Everything in flight after this edge is stale.
                drop_cnt <= outstanding - CNT_W'(resp_ok);
            end else begin
                if (req_fire) begin
                    fpc <= fpc + 64'd4;
                end
                if (resp_ok) begin
                    if (drop_cnt != '0) begin
                        drop_cnt <= drop_cnt - CNT_W'(1);
                    end else begin
                        rpc <= rpc + 64'd4;
                    end
                end
            end
        end
    end

    // Instruction FIFO; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pc_mem[i]   <= '0;
                inst_mem[i] <= '0;
            end
        end else if (redirect_valid) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                pc_mem[wr_ptr]   <= rpc;
                inst_mem[wr_ptr] <= resp_data;
                wr_ptr           <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef IFU_STALL_CNT_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else if (out_ready && !out_valid && (stall_q != '1)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

endmodule
